uart_rx_param: RTL and testbench

Parametrised, runtime-configurable UART receiver that succeeds the fixed 8N2 receiver.
- Supports 5-8 data bits, optional even/odd parity, and 1 or 2 stop bits.
- Synchronises the asynchronous serial input and decides each bit by 3-sample majority vote.
- Reports parity, framing, break and overrun conditions.
- Sits between the baud-tick generator and the RX FIFO; the FIFO write port takes o_rx_valid/o_rx_data directly.

---
 rtl/uart_rx_param.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// UART receiver with runtime-selectable frame format (5-8 data bits,
// optional even/odd parity, 1 or 2 stop bits). The line is synchronised,
// each bit is decided by a 3-sample majority vote around mid-bit, and
// parity, framing, break and overrun conditions are reported.
module uart_rx_param #(
  parameter int MAX_DATA    = 8,
  parameter int OVER_SAMPLE = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_stick,
  input  logic                i_rx_en,
  input  logic                i_fifo_full,
  input  logic                i_rx_data,
  input  logic [1:0]          i_data_bits,
  input  logic                i_parity_en,
  input  logic                i_parity_odd,
  input  logic                i_two_stop,
  output logic [MAX_DATA-1:0] o_rx_data,
  output logic                o_rx_valid,
  output logic                o_parity_err,
  output logic                o_frame_err,
  output logic                o_break,
  output logic                o_overrun,
  output logic                o_busy
);

  localparam int CW = $clog2(OVER_SAMPLE);
  localparam logic [CW-1:0] C_VOTE0 = CW'(OVER_SAMPLE / 2 - 2);
  localparam logic [CW-1:0] C_VOTE1 = CW'(OVER_SAMPLE / 2 - 1);
  localparam logic [CW-1:0] C_VOTE2 = CW'(OVER_SAMPLE / 2);
  localparam logic [CW-1:0] C_END   = CW'(OVER_SAMPLE - 1);
  localparam logic [3:0]    MAX_LAST = 4'(MAX_DATA - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_d;
  logic                   fall;
  logic                   armed;

  logic [CW-1:0]       cnt;
  logic                s0;
  logic                s1;
  logic                vote;
  logic                at_v0;
  logic                at_v1;
  logic                at_v2;
  logic                at_end;

  logic [3:0]          idx;
  logic                stop_idx;
  logic [MAX_DATA-1:0] shift;
  logic                par_acc;
  logic                par_bit;
  logic                frm;
  logic                brk;

  logic [3:0]          cfg_last;
  logic                cfg_par_en;
  logic                cfg_par_odd;
  logic                cfg_two_stop;
  logic [3:0]          req_last;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign fall     = rxs_d & ~rxs;
  assign vote     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign at_v0    = i_stick && (cnt == C_VOTE0);
  assign at_v1    = i_stick && (cnt == C_VOTE1);
  assign at_v2    = i_stick && (cnt == C_VOTE2);
  assign at_end   = i_stick && (cnt == C_END);
  assign req_last = 4'd4 + {2'b00, i_data_bits};
  assign o_busy   = (state != ST_IDLE);

  // Bring the asynchronous line into the clock domain and keep one extra copy for start-edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx_data};
      rxs_d  <= rxs;
    end
  end

  // Frame state machine: tick counting, majority vote, bit assembly and registered result/flag outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      idx          <= '0;
      stop_idx     <= 1'b0;
      shift        <= '0;
      par_acc      <= 1'b0;
      par_bit      <= 1'b0;
      frm          <= 1'b0;
      brk          <= 1'b0;
      armed        <= 1'b1;
      cfg_last     <= '0;
      cfg_par_en   <= 1'b0;
      cfg_par_odd  <= 1'b0;
      cfg_two_stop <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      o_overrun  <= 1'b0;

      if (i_stick) begin
        if (cnt == C_END) cnt <= '0;
        else              cnt <= cnt + CW'(1);
      end
      if (at_v0) s0 <= rxs;
      if (at_v1) s1 <= rxs;

      case (state)
        ST_IDLE: begin
          if (rxs) armed <= 1'b1;
          if (armed && fall && i_rx_en) begin
            state        <= ST_START;
            cnt          <= '0;
            cfg_last     <= (req_last > MAX_LAST) ? MAX_LAST : req_last;
            cfg_par_en   <= i_parity_en;
            cfg_par_odd  <= i_parity_odd;
            cfg_two_stop <= i_two_stop;
            idx          <= '0;
            stop_idx     <= 1'b0;
            shift        <= '0;
            par_acc      <= 1'b0;
            par_bit      <= 1'b0;
            frm          <= 1'b0;
            brk          <= 1'b0;
          end
        end

        ST_START: begin
          if (at_v2 && vote) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (at_end) begin
            state <= ST_DATA;
            cnt   <= '0;
          end
        end

        ST_DATA: begin
          if (at_v2) begin
            for (int i = 0; i < MAX_DATA; i++) begin
              if (idx == 4'(i)) shift[i] <= vote;
            end
            par_acc <= par_acc ^ vote;
          end
          if (at_end) begin
            if (idx == cfg_last) begin
              state <= cfg_par_en ? ST_PARITY : ST_STOP;
              cnt   <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          if (at_v2) par_bit <= vote;
          if (at_end) begin
            state <= ST_STOP;
            cnt   <= '0;
          end
        end

        ST_STOP: begin
          if (at_v2) begin
            if (!vote) frm <= 1'b1;
            if (!stop_idx) begin
              brk <= (shift == '0) && (!cfg_par_en || !par_bit) && !vote;
            end
            if (!cfg_two_stop || stop_idx) begin
              state <= ST_DONE;
              cnt   <= '0;
            end
          end else if (at_end) begin
            stop_idx <= 1'b1;
          end
        end

        ST_DONE: begin
          if (!i_fifo_full) begin
            o_rx_valid   <= 1'b1;
            o_rx_data    <= shift;
            o_parity_err <= cfg_par_en && ((par_acc ^ par_bit) != cfg_par_odd);
            o_frame_err  <= frm;
            o_break      <= brk;
          end else begin
            o_overrun <= 1'b1;
          end
          if (brk) armed <= 1'b0;
          state <= ST_IDLE;
          cnt   <= '0;
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are driven bit by bit, the
// expected result of each frame is queued when it is sent and compared
// when the receiver pulses o_rx_valid or o_overrun.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int BIT_CLKS = 64;

  logic       i_clk;
  logic       i_rst;
  logic       i_stick;
  logic       i_rx_en;
  logic       i_fifo_full;
  logic       i_rx_data;
  logic [1:0] i_data_bits;
  logic       i_parity_en;
  logic       i_parity_odd;
  logic       i_two_stop;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_break;
  logic       o_overrun;
  logic       o_busy;

  typedef struct packed {
    logic       ovr;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   div = 0;

  logic [7:0] last_data;
  logic       last_perr;
  logic       last_ferr;
  logic       last_brk;

  uart_rx_param #(
    .MAX_DATA   (8),
    .OVER_SAMPLE(16),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_stick     (i_stick),
    .i_rx_en     (i_rx_en),
    .i_fifo_full (i_fifo_full),
    .i_rx_data   (i_rx_data),
    .i_data_bits (i_data_bits),
    .i_parity_en (i_parity_en),
    .i_parity_odd(i_parity_odd),
    .i_two_stop  (i_two_stop),
    .o_rx_data   (o_rx_data),
    .o_rx_valid  (o_rx_valid),
    .o_parity_err(o_parity_err),
    .o_frame_err (o_frame_err),
    .o_break     (o_break),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  // Free-running system clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Oversample tick: one clock high out of every four
  always @(negedge i_clk) begin
    div = (div == 3) ? 0 : div + 1;
    i_stick = (div == 0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Hold one bit for a full bit period, optionally inverting a 3-clock window mid-bit
  task automatic drive_bit(input logic v, input bit glitch);
    for (int c = 0; c < BIT_CLKS; c++) begin
      @(negedge i_clk);
      i_rx_data = (glitch && c >= 30 && c < 33) ? ~v : v;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input int nbits, input bit par_en,
                               input bit par_odd, input bit force_pbit, input bit pbit_forced,
                               input bit two_stop, input bit stop1, input bit stop2,
                               input bit expect_out, input int glitch_bit, input bit cfg_scramble);
    logic [7:0] mask;
    logic [7:0] d;
    logic       pbit;
    exp_t       e;
    mask = 8'((1 << nbits) - 1);
    d    = data & mask;
    pbit = force_pbit ? pbit_forced : ((^d) ^ par_odd);
    @(negedge i_clk);
    i_data_bits  = 2'(nbits - 5);
    i_parity_en  = par_en;
    i_parity_odd = par_odd;
    i_two_stop   = two_stop;
    if (expect_out) begin
      if (i_fifo_full) begin
        e.ovr  = 1'b1;
        e.data = last_data;
        e.perr = last_perr;
        e.ferr = last_ferr;
        e.brk  = last_brk;
      end else begin
        e.ovr  = 1'b0;
        e.data = d;
        e.perr = par_en && (((^d) ^ pbit) != par_odd);
        e.ferr = !stop1 || (two_stop && !stop2);
        e.brk  = (d == 8'h00) && (!par_en || !pbit) && !stop1;
        last_data = e.data;
        last_perr = e.perr;
        last_ferr = e.ferr;
        last_brk  = e.brk;
      end
      sb.push_back(e);
    end
    drive_bit(1'b0, 1'b0);
    if (cfg_scramble) begin
      i_data_bits = ~i_data_bits;
      i_parity_en = ~par_en;
      i_two_stop  = ~two_stop;
    end
    for (int i = 0; i < nbits; i++) drive_bit(d[i], i == glitch_bit);
    if (par_en) drive_bit(pbit, 1'b0);
    drive_bit(stop1, 1'b0);
    if (two_stop) drive_bit(stop2, 1'b0);
    i_data_bits = 2'(nbits - 5);
    i_parity_en = par_en;
    i_two_stop  = two_stop;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
  endtask

  // Scoreboard monitor: every valid or overrun pulse consumes one expected entry
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && (o_rx_valid || o_overrun)) begin
      checkOutput("pulse_exclusive", 32'(o_rx_valid & o_overrun), 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_output", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("overrun_kind", 32'(o_overrun), 32'(e.ovr));
        checkOutput("rx_data", 32'(o_rx_data), 32'(e.data));
        checkOutput("parity_err", 32'(o_parity_err), 32'(e.perr));
        checkOutput("frame_err", 32'(o_frame_err), 32'(e.ferr));
        checkOutput("break", 32'(o_break), 32'(e.brk));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_data"}, 32'(o_rx_data), 32'd0);
    checkOutput({tag, "_valid"}, 32'(o_rx_valid), 32'd0);
    checkOutput({tag, "_perr"}, 32'(o_parity_err), 32'd0);
    checkOutput({tag, "_ferr"}, 32'(o_frame_err), 32'd0);
    checkOutput({tag, "_break"}, 32'(o_break), 32'd0);
    checkOutput({tag, "_overrun"}, 32'(o_overrun), 32'd0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    i_rst        = 1'b1;
    i_stick      = 1'b0;
    i_rx_en      = 1'b1;
    i_fifo_full  = 1'b0;
    i_rx_data    = 1'b1;
    i_data_bits  = 2'd3;
    i_parity_en  = 1'b0;
    i_parity_odd = 1'b0;
    i_two_stop   = 1'b0;
    last_data    = 8'h00;
    last_perr    = 1'b0;
    last_ferr    = 1'b0;
    last_brk     = 1'b0;
    repeat (5) @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);

    // 8N1 0xA5 with the configuration inputs changed mid-frame
    applyStimulus(8'hA5, 8, 0, 0, 0, 0, 0, 1, 1, 1, -1, 1);
    checkOutput("busy_after_8n1", 32'(o_busy), 32'd0);

    // 8N1 0xC3 with a short low glitch inside data bit 0 (a 1)
    applyStimulus(8'hC3, 8, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);

    // 7E2 0x35 with correct then wrong parity bit
    applyStimulus(8'h35, 7, 1, 0, 1, 0, 1, 1, 1, 1, -1, 0);
    applyStimulus(8'h35, 7, 1, 0, 1, 1, 1, 1, 1, 1, -1, 0);

    // 5O1: stop bit forced low, then an all-zero break frame, then recovery
    applyStimulus(8'h1F, 5, 1, 1, 0, 0, 0, 0, 1, 1, -1, 0);
    applyStimulus(8'h00, 5, 1, 1, 1, 0, 0, 0, 1, 1, -1, 0);
    applyStimulus(8'h0A, 5, 1, 1, 0, 0, 0, 1, 1, 1, -1, 0);

    // False start: 1-clock low edge, a short low window near the vote ticks, then idle
    i_data_bits = 2'd3;
    i_parity_en = 1'b0;
    i_two_stop  = 1'b0;
    @(negedge i_clk);
    i_rx_data = 1'b0;
    @(negedge i_clk);
    i_rx_data = 1'b1;
    repeat (10) @(negedge i_clk);
    checkOutput("busy_in_start", 32'(o_busy), 32'd1);
    repeat (18) @(negedge i_clk);
    i_rx_data = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rx_data = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge i_clk);
    checkOutput("busy_after_false_start", 32'(o_busy), 32'd0);

    // Receiver disabled: the frame must be ignored
    i_rx_en = 1'b0;
    applyStimulus(8'h99, 8, 0, 0, 0, 0, 0, 1, 1, 0, -1, 0);
    checkOutput("busy_rx_disabled", 32'(o_busy), 32'd0);
    i_rx_en = 1'b1;

    // FIFO full: overrun pulse, data and flags unchanged
    i_fifo_full = 1'b1;
    applyStimulus(8'h77, 8, 0, 0, 0, 0, 0, 1, 1, 1, -1, 0);
    i_fifo_full = 1'b0;
    checkOutput("data_after_overrun", 32'(o_rx_data), 32'(last_data));

    // Reset pulse during data bit 3 of an 8N1 frame
    @(negedge i_clk);
    i_data_bits = 2'd3;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
    repeat (32) @(negedge i_clk);
    checkOutput("busy_mid_data", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_all_zero("mid_reset");
    i_rst = 1'b0;
    last_data = 8'h00;
    last_perr = 1'b0;
    last_ferr = 1'b0;
    last_brk  = 1'b0;
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    applyStimulus(8'h3C, 8, 0, 0, 0, 0, 0, 1, 1, 1, -1, 0);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
